// File: rtl/uart_parse_pkg.sv
// Shared constants and types for the UART decimal-number parser.
// Negative-number support is controlled by the PARSE_NEG_EN macro in uart_num_parser.
package uart_parse_pkg;

    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;
    localparam logic [7:0] CH_SP    = 8'h20;
    localparam logic [7:0] CH_COMMA = 8'h2C;
    localparam logic [7:0] CH_TAB   = 8'h09;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_MINUS = 8'h2D;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DIGIT = 2'd1,
        ST_SIGN  = 2'd2,
        ST_SKIP  = 2'd3
    } parse_state_t;

    // A FIFO entry is {eol_marker, value}.
    function automatic int entry_w(input int val_w);
        return val_w + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_sa.sv
// Generic show-ahead synchronous FIFO: head entry is visible combinationally while not empty.
// DEPTH must be a power of 2 so the pointers wrap naturally.
module sync_fifo_sa #(
    parameter int W     = 9,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_flush,
    input  logic         i_push,
    input  logic [W-1:0] i_push_data,
    input  logic         i_pop,
    output logic [W-1:0] o_head_data,
    output logic         o_empty,
    output logic         o_full,
    output logic         o_drop
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_pop;
    logic          w_push;

    assign o_empty     = (r_count == '0);
    assign o_full      = (r_count == FULL_CNT);
    assign w_pop       = i_pop && !o_empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign w_push      = i_push && (!o_full || w_pop);
    assign o_drop      = i_push && !w_push;
    assign o_head_data = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_num_parser.sv
// Parses ASCII decimal integers from UART bytes into a valid/ready FIFO of values and EOL markers.
// Define PARSE_NEG_EN to accept a leading '-' and parse signed two's-complement values.
module uart_num_parser
    import uart_parse_pkg::*;
#(
    parameter int VAL_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       rx_data,
    input  logic             rx_done,
    input  logic             clear,
    output logic [VAL_W-1:0] num_data,
    output logic             num_eol,
    output logic             num_valid,
    input  logic             num_ready,
    output logic             err_char,
    output logic             err_overflow,
    output logic             fifo_drop,
    output logic [1:0]       dbg_state
);

    // Handshake: the head entry transfers on a cycle where num_valid && num_ready at the clock edge.

    localparam int ACC_W = VAL_W + 4;
    localparam int E_W   = entry_w(VAL_W);

`ifdef PARSE_NEG_EN
    localparam bit NEG_EN = 1'b1;
`else
    localparam bit NEG_EN = 1'b0;
`endif

    localparam logic [ACC_W-1:0] LIM_POS = NEG_EN ? ACC_W'((1 << (VAL_W - 1)) - 1)
                                                  : ACC_W'((1 << VAL_W) - 1);
    localparam logic [ACC_W-1:0] LIM_NEG = ACC_W'(1 << (VAL_W - 1));

    parse_state_t     r_state;
    logic [ACC_W-1:0] r_acc;
    logic             r_neg;
    logic             r_line_open;
    logic             r_pending_eol;
    logic             r_err_char;
    logic             r_err_overflow;
    logic             r_fifo_drop;

    parse_state_t     w_state_nx;
    logic [ACC_W-1:0] w_acc_nx;
    logic             w_neg_nx;
    logic             w_line_open_nx;
    logic             w_pending_nx;
    logic             w_push_val;
    logic             w_push_eol;
    logic             w_err_char;
    logic             w_err_ovf;
    logic             w_do_skip;

    logic             w_is_dig;
    logic             w_is_sep;
    logic             w_is_eol;
    logic             w_is_minus;
    logic [ACC_W-1:0] w_digit;
    logic [ACC_W-1:0] w_acc_next;
    logic [ACC_W-1:0] w_limit;
    logic [VAL_W-1:0] w_value;

    logic             w_push;
    logic [E_W-1:0]   w_push_data;
    logic [E_W-1:0]   w_head;
    logic             w_empty;
    logic             w_full;
    logic             w_drop;

    assign w_is_dig   = (rx_data >= CH_0) && (rx_data <= CH_9);
    assign w_is_sep   = (rx_data == CH_SP) || (rx_data == CH_COMMA) || (rx_data == CH_TAB);
    assign w_is_eol   = (rx_data == CH_CR) || (rx_data == CH_LF);
    assign w_is_minus = NEG_EN && (rx_data == CH_MINUS);
    assign w_digit    = ACC_W'(rx_data[3:0]);
    assign w_acc_next = r_acc * ACC_W'(10) + w_digit;
    assign w_limit    = r_neg ? LIM_NEG : LIM_POS;
    assign w_value    = r_neg ? (VAL_W'(0) - r_acc[VAL_W-1:0]) : r_acc[VAL_W-1:0];

    always_comb begin
        w_state_nx     = r_state;
        w_acc_nx       = r_acc;
        w_neg_nx       = r_neg;
        w_line_open_nx = r_line_open;
        w_pending_nx   = 1'b0;
        w_push_val     = 1'b0;
        w_push_eol     = 1'b0;
        w_err_char     = 1'b0;
        w_err_ovf      = 1'b0;
        w_do_skip      = 1'b0;
        if (rx_done) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_is_dig) begin
                        w_acc_nx   = w_digit;
                        w_neg_nx   = 1'b0;
                        w_state_nx = ST_DIGIT;
                    end else if (w_is_sep) begin
                        w_state_nx = ST_IDLE;
                    end else if (w_is_eol) begin
                        w_push_eol     = r_line_open;
                        w_line_open_nx = 1'b0;
                    end else if (w_is_minus) begin
                        w_state_nx = ST_SIGN;
                    end else begin
                        w_err_char = 1'b1;
                        w_state_nx = ST_SKIP;
                    end
                end
                ST_DIGIT: begin
                    if (w_is_dig) begin
                        if (w_acc_next > w_limit) begin
                            w_err_ovf  = 1'b1;
                            w_state_nx = ST_SKIP;
                        end else begin
                            w_acc_nx = w_acc_next;
                        end
                    end else if (w_is_sep) begin
                        w_push_val     = 1'b1;
                        w_line_open_nx = 1'b1;
                        w_state_nx     = ST_IDLE;
                    end else if (w_is_eol) begin
                        // Value goes now, its marker one cycle later.
                        w_push_val     = 1'b1;
                        w_pending_nx   = 1'b1;
                        w_line_open_nx = 1'b0;
                        w_state_nx     = ST_IDLE;
                    end else begin
                        w_err_char = 1'b1;
                        w_state_nx = ST_SKIP;
                    end
                end
                ST_SIGN: begin
                    if (w_is_dig) begin
                        w_acc_nx   = w_digit;
                        w_neg_nx   = 1'b1;
                        w_state_nx = ST_DIGIT;
                    end else begin
                        w_err_char = 1'b1;
                        w_do_skip  = 1'b1;
                    end
                end
                default: w_do_skip = 1'b1;
            endcase
            if (w_do_skip) begin
                if (w_is_sep) begin
                    w_state_nx = ST_IDLE;
                end else if (w_is_eol) begin
                    w_push_eol     = r_line_open;
                    w_line_open_nx = 1'b0;
                    w_state_nx     = ST_IDLE;
                end else begin
                    w_state_nx = ST_SKIP;
                end
            end
        end
    end

    assign w_push      = !clear && (w_push_val || w_push_eol || r_pending_eol);
    assign w_push_data = w_push_val ? {1'b0, w_value} : {1'b1, VAL_W'(0)};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_acc          <= '0;
            r_neg          <= 1'b0;
            r_line_open    <= 1'b0;
            r_pending_eol  <= 1'b0;
            r_err_char     <= 1'b0;
            r_err_overflow <= 1'b0;
            r_fifo_drop    <= 1'b0;
        end else if (clear) begin
            r_state        <= ST_IDLE;
            r_acc          <= '0;
            r_neg          <= 1'b0;
            r_line_open    <= 1'b0;
            r_pending_eol  <= 1'b0;
            r_err_char     <= 1'b0;
            r_err_overflow <= 1'b0;
            r_fifo_drop    <= 1'b0;
        end else begin
            r_state        <= w_state_nx;
            r_acc          <= w_acc_nx;
            r_neg          <= w_neg_nx;
            r_line_open    <= w_line_open_nx;
            r_pending_eol  <= w_pending_nx;
            r_err_char     <= w_err_char;
            r_err_overflow <= w_err_ovf;
            r_fifo_drop    <= w_drop;
        end
    end

    sync_fifo_sa #(
        .W     (E_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_flush     (clear),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (num_ready),
        .o_head_data (w_head),
        .o_empty     (w_empty),
        .o_full      (w_full),
        .o_drop      (w_drop)
    );

    assign num_valid    = !w_empty;
    assign num_eol      = w_head[E_W-1];
    assign num_data     = w_head[VAL_W-1:0];
    assign err_char     = r_err_char;
    assign err_overflow = r_err_overflow;
    assign fifo_drop    = r_fifo_drop;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_uart_num_parser.sv
// Self-checking bench for uart_num_parser: token-level reference model feeding a scoreboard queue.
// Build with +define+PARSE_NEG_EN to exercise signed parsing.
module tb_uart_num_parser;

    localparam int VAL_W = 8;
    localparam int DEPTH = 4;
`ifdef PARSE_NEG_EN
    localparam bit NEG_EN = 1'b1;
`else
    localparam bit NEG_EN = 1'b0;
`endif

    // clock / reset
    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [7:0]       rx_data = 8'h00;
    logic             rx_done = 1'b0;
    logic             clear = 1'b0;
    logic             num_ready = 1'b0;
    logic [VAL_W-1:0] num_data;
    logic             num_eol;
    logic             num_valid;
    logic             err_char;
    logic             err_overflow;
    logic             fifo_drop;
    logic [1:0]       dbg_state;

    always #5 clk = ~clk;

    uart_num_parser #(.VAL_W(VAL_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_data      (rx_data),
        .rx_done      (rx_done),
        .clear        (clear),
        .num_data     (num_data),
        .num_eol      (num_eol),
        .num_valid    (num_valid),
        .num_ready    (num_ready),
        .err_char     (err_char),
        .err_overflow (err_overflow),
        .fifo_drop    (fifo_drop),
        .dbg_state    (dbg_state)
    );

    // scoreboard state
    int               n_pass = 0;
    int               n_total = 0;
    logic [VAL_W:0]   exp_q[$];
    logic [7:0]       tok[$];
    bit               line_open = 1'b0;
    int               exp_err_char, exp_ovf, exp_drop;
    int               seen_err_char, seen_ovf, seen_drop, seen_entries;
    int               rdy_mode = 1;
    bit               throttle = 1'b0;
    bit               prev_done = 1'b0;

    function automatic void chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endfunction

    // reference model: work on whole tokens between delimiters
    function automatic void emit(input logic eol, input logic [VAL_W-1:0] d);
        if (exp_q.size() >= DEPTH) exp_drop++;
        else exp_q.push_back({eol, d});
    endfunction

    function automatic void eval_token(input bit is_eol);
        bit ok = 1'b0;
        bit neg = 1'b0;
        int v = 0;
        int p = 0;
        int lim;
        if (tok.size() > 0) begin
            ok = 1'b1;
            if (NEG_EN && tok[0] == 8'h2D) begin
                neg = 1'b1;
                p = 1;
            end
            lim = NEG_EN ? (neg ? (2 ** (VAL_W - 1)) : (2 ** (VAL_W - 1) - 1)) : (2 ** VAL_W - 1);
            if (p >= tok.size()) begin
                ok = 1'b0;
                exp_err_char++;
            end
            for (int i = p; i < tok.size() && ok; i++) begin
                if (tok[i] >= 8'h30 && tok[i] <= 8'h39) begin
                    v = v * 10 + int'(tok[i] - 8'h30);
                    if (v > lim) begin
                        ok = 1'b0;
                        exp_ovf++;
                    end
                end else begin
                    ok = 1'b0;
                    exp_err_char++;
                end
            end
        end
        if (ok) emit(1'b0, VAL_W'(neg ? -v : v));
        if (is_eol) begin
            if (ok || line_open) emit(1'b1, '0);
            line_open = 1'b0;
        end else if (ok) begin
            line_open = 1'b1;
        end
        tok.delete();
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        if (b == 8'h20 || b == 8'h2C || b == 8'h09) eval_token(1'b0);
        else if (b == 8'h0D || b == 8'h0A) eval_token(1'b1);
        else tok.push_back(b);
    endfunction

    function automatic void model_reset();
        tok.delete();
        line_open = 1'b0;
    endfunction

    // monitor: pops the scoreboard whenever the DUT hands over an entry
    initial forever begin
        logic [VAL_W:0] e;
        @(negedge clk);
        if (rx_done && prev_done) begin
            n_total++;
            $display("FAIL rx_spacing: got back-to-back rx_done, required gap of 2 cycles");
        end
        prev_done = rx_done;
        if (rst_n) begin
            if (err_char) seen_err_char++;
            if (err_overflow) seen_ovf++;
            if (fifo_drop) seen_drop++;
            if (num_valid && num_ready) begin
                seen_entries++;
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_entry: got eol=%0b data=0x%0h, expected no entry", num_eol, num_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("fifo_entry", int'({num_eol, num_data}), int'(e));
                end
            end
        end
    end

    // consumer ready: 0 = hold, 1 = always, 2 = random
    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       num_ready = 1'b0;
            1:       num_ready = 1'b1;
            default: num_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // driver tasks
    task automatic send_byte(input logic [7:0] b);
        int w = 0;
        while (throttle && exp_q.size() > DEPTH - 2 && w < 500) begin
            @(posedge clk);
            w++;
        end
        if (w >= 500) begin
            n_total++;
            $display("FAIL throttle_timeout: got %0d queued entries, required <= %0d", exp_q.size(), DEPTH - 2);
        end
        @(posedge clk);
        #1;
        rx_data = b;
        rx_done = 1'b1;
        model_byte(b);
        @(posedge clk);
        #1;
        rx_done = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic start_test();
        exp_err_char = 0;
        exp_ovf = 0;
        exp_drop = 0;
        seen_err_char = 0;
        seen_ovf = 0;
        seen_drop = 0;
        seen_entries = 0;
    endtask

    task automatic finish_test(input string name, input int exp_entries);
        int w = 0;
        rdy_mode = 1;
        while (exp_q.size() != 0 && w < 200) begin
            @(posedge clk);
            w++;
        end
        repeat (6) @(posedge clk);
        chk({name, "_left_in_queue"}, exp_q.size(), 0);
        exp_q.delete();
        chk({name, "_err_char"}, seen_err_char, exp_err_char);
        chk({name, "_err_overflow"}, seen_ovf, exp_ovf);
        chk({name, "_fifo_drop"}, seen_drop, exp_drop);
        if (exp_entries >= 0) chk({name, "_entries"}, seen_entries, exp_entries);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        int r;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_num_valid", int'(num_valid), 0);
        chk("reset_num_data", int'(num_data), 0);
        chk("reset_num_eol", int'(num_eol), 0);
        chk("reset_err_char", int'(err_char), 0);
        chk("reset_err_overflow", int'(err_overflow), 0);
        chk("reset_fifo_drop", int'(fifo_drop), 0);
        chk("reset_state", int'(dbg_state), 0);

        start_test();
        send_str("12 34\r\n");
        finish_test("crlf", 3);

        start_test();
        send_str("255,256\n");
        finish_test("overflow", 2);

        start_test();
        send_str("1a2 7\n");
        finish_test("bad_char", 2);

        start_test();
        rdy_mode = 0;
        send_str("1 2 3 4 5\n");
        finish_test("fifo_full", 4);

        start_test();
        send_str("-128 127 -129\n");
        finish_test("negative", NEG_EN ? 3 : 2);

        start_test();
        send_str("12");
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        send_str("3\n");
        finish_test("mid_reset", 2);

        start_test();
        rdy_mode = 0;
        send_str("1 2 ");
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("clear_pre_valid", int'(num_valid), 1);
        @(posedge clk);
        #1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        @(negedge clk);
        chk("clear_post_valid", int'(num_valid), 0);
        exp_q.delete();
        model_reset();
        rdy_mode = 1;
        send_str("9\n");
        finish_test("clear", 2);

        start_test();
        throttle = 1'b1;
        rdy_mode = 2;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 55) b = 8'h30 + 8'($urandom_range(0, 9));
            else if (r < 62) b = 8'h20;
            else if (r < 67) b = 8'h2C;
            else if (r < 70) b = 8'h09;
            else if (r < 76) b = 8'h0D;
            else if (r < 82) b = 8'h0A;
            else if (r < 92) b = 8'h2D;
            else b = 8'h41 + 8'($urandom_range(0, 25));
            send_byte(b);
        end
        send_byte(8'h0A);
        throttle = 1'b0;
        finish_test("random", -1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_num_parser.md
Name: uart_num_parser

Overview:
Downstream of the UART receiver. Consumes received bytes (rx_data qualified by a one-cycle rx_done pulse) and parses ASCII decimal integers separated by space, comma or tab, with lines ended by CR/LF. Parsed values and end-of-line markers go into a small show-ahead FIFO with a valid/ready interface. The matrix-entry controller drains that FIFO.

Parameters:
VAL_W, 8, width of a parsed value.
FIFO_DEPTH, 4, number of FIFO entries; must be a power of 2 and at least 2.

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
rx_data  input  8  received byte from the UART receiver
rx_done  input  1  one-cycle strobe qualifying rx_data
clear  input  1  synchronous flush of parser and FIFO
num_data  output  VAL_W  value at the FIFO head
num_eol  output  1  head entry is an end-of-line marker; num_data is 0 for markers
num_valid  output  1  FIFO not empty
num_ready  input  1  consumer accepts the head entry when num_valid && num_ready
err_char  output  1  one-cycle pulse on an invalid character
err_overflow  output  1  one-cycle pulse when a value exceeds its range
fifo_drop  output  1  one-cycle pulse when a push is lost because the FIFO is full

Behaviour:
- Reset state: parser in IDLE; accumulator and line_open cleared; FIFO empty. All outputs are 0.
- Character classes:
  - DIG: '0'-'9' (0x30-0x39)
  - SEP: 0x20, 0x2C, 0x09
  - EOL: 0x0D, 0x0A
  - MINUS: 0x2D
  - Anything else is invalid.
- States:
  - IDLE
    - DIG: acc = digit, go to DIGIT.
    - SEP: stay.
    - EOL: if line_open, push marker and clear line_open; stay.
    - Invalid: err_char, go to SKIP.
  - DIGIT
    - DIG: acc = acc*10 + digit. The accumulator is VAL_W+4 bits wide internally. If the result exceeds the range limit: err_overflow, go to SKIP, no value pushed.
    - SEP: push value, set line_open, go to IDLE.
    - EOL: push value, then push marker on the next cycle (pending_eol register), clear line_open, go to IDLE.
    - Invalid: err_char, go to SKIP.
  - SKIP: discard bytes until SEP (go to IDLE) or EOL (treated as EOL in IDLE).
- A value abandoned through SKIP does not set line_open. line_open is only set by an earlier successfully pushed value.
- CR LF: the CR emits the marker. The LF then sees line_open=0 and emits nothing.
- Range without the optional feature is unsigned 0..2^VAL_W-1. Leading zeros are allowed.
- Input constraint: consecutive rx_done pulses are at least 2 cycles apart (UART guarantees about 10*BAUD_DIV). The bench asserts this.
- FIFO:
  - Show-ahead: num_data/num_eol reflect the head combinationally from storage.
  - Pop on num_valid && num_ready.
  - A push is accepted when not full, or when full with a pop in the same cycle.
  - Otherwise the entry is dropped and fifo_drop pulses. A dropped value still sets line_open.
  - Pointers wrap modulo FIFO_DEPTH; a count register distinguishes full from empty.
- clear: highest priority. It empties the FIFO, returns the parser to IDLE, cancels pending_eol, and ignores a coincident rx_done.
- Reset mid-token discards all partial state.

Optional Feature:
PARSE_NEG_EN
- Defined: MINUS in IDLE goes to a SIGN state.
  - SIGN + DIG: go to DIGIT with neg=1.
  - SIGN + anything else: err_char, then handle as in SKIP.
  - Range becomes signed, -2^(VAL_W-1)..2^(VAL_W-1)-1. The limit is 2^(VAL_W-1) when neg=1, else 2^(VAL_W-1)-1.
  - A value is pushed as two's complement, negated when neg=1.
- Undefined: MINUS is an invalid character and the unsigned range applies.

Decomposition:
- Package uart_parse_pkg holds:
  - ASCII constants: CH_0, CH_9, CH_SP, CH_COMMA, CH_TAB, CH_CR, CH_LF, CH_MINUS
  - the parser state enum (IDLE, DIGIT, SIGN, SKIP)
  - the FIFO entry width function (VAL_W+1)
- Sub-module: sync_fifo_sa, a generic show-ahead synchronous FIFO parameterised by width and depth. The parser FSM stays in uart_num_parser.

Test Plan:
- "12 34\r\n", num_ready=1 → entries 12, 34, then marker (num_eol=1, num_data=0); no marker from the LF; no error pulses.
- "255,256\n" (unsigned) → 255; err_overflow on the '6'; marker on LF; exactly 2 entries.
- "1a2 7\n" → err_char on 'a'; "2" is skipped; then 7 and a marker.
- num_ready=0, "1 2 3 4 5\n", depth 4 → FIFO holds 1,2,3,4; fifo_drop pulses twice (value 5 and marker). Releasing num_ready drains exactly 4 entries.
- PARSE_NEG_EN: "-128 127 -129\n" → 0x80, 0x7F, err_overflow, marker. Without the macro, the same input gives err_char on each '-', entry 127, then marker.
- "12", assert rst_n low for 3 cycles, then "3\n" → entries 3 and marker only. Also: clear asserted between bytes empties a non-empty FIFO in 1 cycle.
